// File: rtl/mmio_console_if.sv
// CPU data-port bundle for the MMIO console: address/strobes/write data from the CPU,
// window-hit and registered read data back from the console.
interface mmio_console_if;
    logic [31:0] dmem_addr_i;
    logic        dmem_ren_i;
    logic        dmem_wen_i;
    logic [31:0] dmem_wdata_i;
    logic        sel_o;
    logic [31:0] dmem_rdata_o;

    modport master (
        output dmem_addr_i, dmem_ren_i, dmem_wen_i, dmem_wdata_i,
        input  sel_o, dmem_rdata_o
    );

    modport slave (
        input  dmem_addr_i, dmem_ren_i, dmem_wen_i, dmem_wdata_i,
        output sel_o, dmem_rdata_o
    );
endinterface

// File: rtl/mmio_console.sv
// Memory-mapped console: TX byte FIFO feeding an 8N1 serializer, STATUS readback and a
// sticky TOHOST halt/exit-code latch. Define MMIO_CONSOLE_TRACE_EN to echo traffic in simulation.
module mmio_console #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          BAUD_DIV   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mmio_console_if.slave bus,
    output logic          tx_o,
    output logic          halt_o,
    output logic [31:0]   exit_code_o
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(BAUD_DIV);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              ovf_reg;
    state_t            state_reg;
    logic [BAUD_W-1:0] baud_cnt_reg;
    logic [2:0]        bit_cnt_reg;
    logic [7:0]        shift_reg;
    logic              tx_reg;
    logic [31:0]       rdata_reg;
    logic              halt_reg;
    logic [31:0]       exit_code_reg;

    logic        aligned, wr_txdata, rd_status, wr_tohost;
    logic        full, empty, push, pop, baud_end;
    logic [31:0] status_word, rdata_next;

    assign bus.sel_o = (bus.dmem_addr_i[31:4] == BASE_ADDR[31:4]);
    assign aligned   = (bus.dmem_addr_i[1:0] == 2'b00);
    assign wr_txdata = bus.sel_o && bus.dmem_wen_i && aligned && (bus.dmem_addr_i[3:2] == 2'd0);
    assign rd_status = bus.sel_o && bus.dmem_ren_i && aligned && (bus.dmem_addr_i[3:2] == 2'd1);
    assign wr_tohost = bus.sel_o && bus.dmem_wen_i && aligned && (bus.dmem_addr_i[3:2] == 2'd2);

    assign full     = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_reg == '0);
    assign baud_end = (baud_cnt_reg == BAUD_W'(BAUD_DIV - 1));
    // Fullness is judged before this cycle's pop, so a write into a full FIFO is lost even if a byte leaves.
    assign push     = wr_txdata && !full;
    // Popping at the end of STOP lets the next frame's start bit follow the stop bit directly.
    assign pop      = !empty && ((state_reg == IDLE) || (state_reg == STOP && baud_end));

    assign status_word = {16'h0, 8'(count_reg), 4'h0, ovf_reg, (state_reg != IDLE), empty, full};
    assign rdata_next  = rd_status ? status_word : 32'h0;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= bus.dmem_wdata_i[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push && !pop)
                count_reg <= count_reg + CNT_W'(1);
            else if (!push && pop)
                count_reg <= count_reg - CNT_W'(1);
            if (wr_txdata && full)
                ovf_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        state_reg    <= START;
                        shift_reg    <= fifo_mem[rd_ptr_reg];
                        baud_cnt_reg <= '0;
                        tx_reg       <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        state_reg    <= DATA;
                        baud_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                        tx_reg       <= shift_reg[0];
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt_reg <= '0;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= STOP;
                            tx_reg    <= 1'b1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            shift_reg   <= shift_reg >> 1;
                            tx_reg      <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt_reg <= '0;
                        if (pop) begin
                            state_reg <= START;
                            shift_reg <= fifo_mem[rd_ptr_reg];
                            tx_reg    <= 1'b0;
                        end else begin
                            state_reg <= IDLE;
                            tx_reg    <= 1'b1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_reg     <= 32'h0;
            halt_reg      <= 1'b0;
            exit_code_reg <= 32'h0;
        end else begin
            rdata_reg <= rdata_next;
            if (wr_tohost && !halt_reg) begin
                halt_reg      <= 1'b1;
                exit_code_reg <= bus.dmem_wdata_i;
            end
        end
    end

`ifdef MMIO_CONSOLE_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (push)
                $write("%c", bus.dmem_wdata_i[7:0]);
            if (wr_tohost && !halt_reg)
                $display("EXIT %0d", bus.dmem_wdata_i);
        end
    end
`endif

    assign bus.dmem_rdata_o = rdata_reg;
    assign tx_o             = tx_reg;
    assign halt_o           = halt_reg;
    assign exit_code_o      = exit_code_reg;
endmodule

// File: tb/tb_mmio_console.sv
// Bench for mmio_console: a queue/frame-level reference model checked every cycle,
// directed scenarios with hand-computed expectations, then a randomized bus phase.
module tb_mmio_console;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 8;
    localparam int          BAUD  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx, halt;
    logic [31:0] exit_code;

    mmio_console_if bus_if();

    mmio_console #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .BAUD_DIV(BAUD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if),
        .tx_o        (tx),
        .halt_o      (halt),
        .exit_code_o (exit_code)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus "which bit of which frame is on the wire".
    byte unsigned q[$];
    bit           m_valid = 0;
    bit           m_ovf, m_halt, m_active;
    int           m_pos;
    logic [7:0]   m_cur;
    logic [31:0]  m_exit, exp_rdata;
    logic         exp_tx;

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] a, rd;
        logic        hit;
        logic [3:0]  off;
        bit          full_pre;
        a        = bus_if.dmem_addr_i;
        hit      = (a[31:4] == BASE[31:4]);
        off      = a[3:0];
        m_valid  = 1;
        if (!rst_n) begin
            q.delete();
            m_ovf = 0; m_halt = 0; m_active = 0; m_pos = 0; m_cur = 8'h0;
            m_exit = 32'h0; exp_rdata = 32'h0; exp_tx = 1'b1;
        end else begin
            rd = 32'h0;
            if (bus_if.dmem_ren_i && hit && off == 4'h4)
                rd = {16'h0, 8'(q.size()), 4'h0, m_ovf, m_active, (q.size() == 0), (q.size() == DEPTH)};
            full_pre = (q.size() == DEPTH);
            if (m_active) begin
                m_pos++;
                if (m_pos == 10 * BAUD) m_active = 0;
            end
            if (!m_active && q.size() > 0) begin
                m_cur    = q.pop_front();
                m_active = 1;
                m_pos    = 0;
            end
            if (bus_if.dmem_wen_i && hit && off == 4'h0) begin
                if (!full_pre) q.push_back(bus_if.dmem_wdata_i[7:0]);
                else           m_ovf = 1;
            end
            if (bus_if.dmem_wen_i && hit && off == 4'h8 && !m_halt) begin
                m_halt = 1;
                m_exit = bus_if.dmem_wdata_i;
            end
            exp_rdata = rd;
            exp_tx    = m_active ? frame_bit(m_cur, m_pos / BAUD) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("tx",        tx,                  exp_tx);
            chk("rdata",     bus_if.dmem_rdata_o, exp_rdata);
            chk("halt",      halt,                m_halt);
            chk("exit_code", exit_code,           m_exit);
            chk("sel",       bus_if.sel_o,        bus_if.dmem_addr_i[31:4] == BASE[31:4]);
        end
    end

    task automatic step(input logic r, input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] d);
        @(negedge clk);
        #1;
        rst_n               = r;
        bus_if.dmem_addr_i  = a;
        bus_if.dmem_ren_i   = rd;
        bus_if.dmem_wen_i   = wr;
        bus_if.dmem_wdata_i = d;
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [39:0] got, want;
        logic [9:0]  pat;
        int          wr_pct;
        logic [31:0] a;

        bus_if.dmem_addr_i  = 32'h0;
        bus_if.dmem_ren_i   = 1'b0;
        bus_if.dmem_wen_i   = 1'b0;
        bus_if.dmem_wdata_i = 32'h0;
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // STATUS straight after reset: only "empty" set.
        step(1'b1, BASE + 32'h4, 1'b1, 1'b0, 32'h0);
        sample();
        chk("status_after_reset", bus_if.dmem_rdata_o, 32'h0000_0002);
        $display("reset status read: %08h", bus_if.dmem_rdata_o);

        // One 'A' frame: start, 1,0,0,0,0,0,1,0, stop at 4 cycles per bit.
        step(1'b1, BASE, 1'b0, 1'b1, 32'h41);
        sample();
        chk("tx_idle_before_frame", tx, 1'b1);
        pat = 10'b1_0100_0001_0;
        for (int k = 0; k < 40; k++) begin
            want[k] = pat[k/4];
            idle(1);
            sample();
            got[k] = tx;
        end
        chk("frame_0x41", got, want);
        idle(1);
        sample();
        chk("tx_high_after_frame", tx, 1'b1);
        $display("frame 0x41 captured: %010h", got);

        // Nine writes while the first frame is on the wire fill the FIFO; a tenth overflows.
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 9; i++) step(1'b1, BASE, 1'b0, 1'b1, 32'h30 + i);
        step(1'b1, BASE + 32'h4, 1'b1, 1'b0, 32'h0);
        sample();
        chk("status_full", bus_if.dmem_rdata_o, 32'h0000_0805);
        step(1'b1, BASE, 1'b0, 1'b1, 32'hEE);
        step(1'b1, BASE + 32'h4, 1'b1, 1'b0, 32'h0);
        sample();
        chk("status_overflow", bus_if.dmem_rdata_o, 32'h0000_080D);
        $display("overflow status read: %08h", bus_if.dmem_rdata_o);
        idle(380);
        step(1'b1, BASE + 32'h4, 1'b1, 1'b0, 32'h0);
        sample();
        chk("status_drained_ovf_sticky", bus_if.dmem_rdata_o, 32'h0000_000A);

        // TOHOST: the first write wins.
        step(1'b1, BASE + 32'h8, 1'b0, 1'b1, 32'h1);
        step(1'b1, BASE + 32'h8, 1'b0, 1'b1, 32'h5);
        sample();
        chk("halt_set", halt, 1'b1);
        chk("exit_code_first", exit_code, 32'h1);
        idle(3);
        sample();
        chk("exit_code_persist", exit_code, 32'h1);
        $display("tohost: halt=%0d exit=%0h", halt, exit_code);

        // Write outside the window.
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h2000_0000, 1'b0, 1'b1, 32'h55);
        #1;
        chk("sel_out_of_window", bus_if.sel_o, 1'b0);
        step(1'b1, BASE + 32'h4, 1'b1, 1'b0, 32'h0);
        sample();
        chk("status_after_foreign_write", bus_if.dmem_rdata_o, 32'h0000_0002);
        chk("tx_after_foreign_write", tx, 1'b1);

        // Reset in the middle of a 0x00 data phase with three bytes still queued.
        for (int i = 0; i < 4; i++) step(1'b1, BASE, 1'b0, 1'b1, 32'h0);
        idle(8);
        sample();
        chk("tx_low_in_data", tx, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        sample();
        chk("tx_after_midframe_reset", tx, 1'b1);
        chk("halt_after_reset", halt, 1'b0);
        step(1'b1, BASE + 32'h4, 1'b1, 1'b0, 32'h0);
        sample();
        chk("status_after_midframe_reset", bus_if.dmem_rdata_o, 32'h0000_0002);
        $display("mid-frame reset status: %08h", bus_if.dmem_rdata_o);

        // Randomized bus traffic, alternating busy and sparse write phases.
        for (int n = 0; n < 4000; n++) begin
            wr_pct = ((n / 500) % 2 == 0) ? 35 : 3;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = BASE;
                4, 5:       a = BASE + 32'h4;
                6:          a = ($urandom_range(0, 63) == 0) ? BASE + 32'h8 : BASE;
                7:          a = BASE + 32'hC;
                8:          a = BASE | 32'($urandom_range(0, 15));
                default:    a = $urandom;
            endcase
            step(($urandom_range(0, 299) != 0), a, ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 99) < wr_pct), $urandom);
        end
        idle(4);
        sample();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mmio_console.md
MMIO_CONSOLE -- requirements
Module: mmio_console

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset.
REQ-002 Parameter BASE_ADDR, default 32'h1000_0000, SHALL set the base of the 16-byte register window.
REQ-003 Parameter FIFO_DEPTH, default 8, SHALL set the TX FIFO entry count (power of two, >=2).
REQ-004 Parameter BAUD_DIV, default 16, SHALL set the clock cycles per serial bit (>=2).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 dmem_addr_i  input  32  CPU data-port byte address.
REQ-008 dmem_ren_i  input  1  CPU data-port read enable.
REQ-009 dmem_wen_i  input  1  CPU data-port write enable.
REQ-010 dmem_wdata_i  input  32  CPU data-port write data.
REQ-011 sel_o  input-decoded output  1  combinational window hit: addr[31:4]==BASE_ADDR[31:4]; top muxes read data on the registered copy.
REQ-012 dmem_rdata_o  output  32  registered read data.
REQ-013 tx_o  output  1  serial TX line.
REQ-014 halt_o  output  1  sticky test-termination flag.
REQ-015 exit_code_o  output  32  value written to TOHOST.

Function
REQ-016 Register offsets SHALL be 0x0 TXDATA (write-only), 0x4 STATUS (read-only), 0x8 TOHOST (write-only); offsets 0xC and any offset with addr[1:0]!=0 SHALL be reserved.
REQ-017 Accesses with sel_o=0 SHALL cause no state change.
REQ-018 Reads SHALL have 1-cycle latency: dmem_rdata_o is valid the cycle after a cycle with dmem_ren_i=1 and sel_o=1, and is 0 otherwise.
REQ-019 STATUS read data: bit0 full, bit1 empty, bit2 serializer busy, bit3 sticky overflow, bits[15:8] FIFO count, all other bits 0; TXDATA, TOHOST and reserved offsets SHALL read 0.
REQ-020 A TXDATA write SHALL push wdata[7:0] if the FIFO is not full at the start of that cycle; otherwise it SHALL be dropped and set overflow, even if a pop occurs in the same cycle.
REQ-021 Overflow SHALL clear only on reset.
REQ-022 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 The serializer FSM SHALL have states IDLE, START, DATA, STOP.
REQ-024 IDLE->START when FIFO is non-empty; the pop occurs in the transition cycle.
REQ-025 The frame SHALL be 1 start bit (0), then 8 data bits LSB-first, then 1 stop bit (1), each bit held exactly BAUD_DIV cycles, and STOP->IDLE afterwards.
REQ-026 tx_o SHALL be 1 in IDLE; back-to-back bytes SHALL follow with no idle cycle between frames.
REQ-027 The first TOHOST write SHALL set halt_o=1 and latch exit_code_o=wdata; later TOHOST writes SHALL be ignored.
REQ-028 Writes to reserved offsets SHALL be ignored.
REQ-029 Simultaneous dmem_ren_i and dmem_wen_i SHALL perform both; the read returns pre-write state.

Reset
REQ-030 While rst_n=0 at a clock edge: FIFO empty, pointers 0, overflow 0, FSM IDLE, bit/baud counters 0, tx_o=1, dmem_rdata_o=0, halt_o=0, exit_code_o=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame and discard all FIFO contents.

Configuration
REQ-032 With macro MMIO_CONSOLE_TRACE_EN defined, each accepted TXDATA push SHALL print its character to the simulator console, and the accepted TOHOST write SHALL print "EXIT <code>".
REQ-033 Without MMIO_CONSOLE_TRACE_EN, no simulation output code SHALL be compiled and behaviour SHALL otherwise be identical.

Verification
REQ-034 BAUD_DIV=4, write 0x41 to 0x1000_0000 -> tx_o low 4 cycles, then 1,0,0,0,0,0,1,0 at 4 cycles each, then high 4 cycles; 40 cycles total.
REQ-035 9 TXDATA writes with FIFO_DEPTH=8 while the serializer is stalled on the first frame -> the first byte is popped, the rest accepted, then STATUS bit0=1 and bit3=0; a further write -> bit3=1 and the byte is never transmitted.
REQ-036 Read 0x1000_0004 after reset -> next-cycle dmem_rdata_o=32'h0000_0002.
REQ-037 Write 0x1 then 0x5 to 0x1000_0008 -> halt_o=1 and exit_code_o=1 persist.
REQ-038 Write 0x55 to 0x2000_0000 -> sel_o=0, FIFO count stays 0, tx_o stays 1.
REQ-039 Assert rst_n=0 during the DATA state with 3 bytes queued -> next cycle tx_o=1, STATUS=0x0000_0002.
